hazard_ctrl: RTL

Parametrised scoreboard-based data-hazard and control-flush unit for the OTTER pipeline. It sits beside the decode stage and tracks every in-flight register write between EX and writeback in an internal shift-register scoreboard. Each cycle it decides whether the decode instruction issues, stalls or is flushed, and which pipeline stage, if any, supplies each of its source operands. It generalises the earlier single-stage rs/rd comparator to arbitrary pipeline depth, load latency and optional forwarding.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_decode.sv | 24 ++
 rtl/hazard_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the OTTER hazard/flush unit.
package hazard_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  // Forward selects encode 0 (regfile) plus one code per scoreboard stage.
  function automatic int fwd_sel_w(input int depth);
    return (depth + 1 <= 2) ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/hazard_decode.sv
// Combinational operand/destination decode of a 32-bit OTTER instruction.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] ir,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd,
  output logic        is_load,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);
  logic [6:0] opc;

  assign opc       = ir[6:0];
  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];
  assign rd        = ir[11:7];
  assign uses_rs1  = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  assign uses_rs2  = (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
  assign writes_rd = !(opc == OPC_BRANCH || opc == OPC_STORE) && (rd != 5'd0);
  assign is_load   = (opc == OPC_LOAD);
endmodule

// File: rtl/hazard_ctrl.sv
// Scoreboard-based data-hazard / control-flush unit beside the decode stage.
// Build option: HZD_FORWARD_EN enables operand forwarding (only load-use stalls).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WB_DEPTH = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     de_ir,
  input  logic                            de_valid,
  input  logic                            br_taken,
  output logic                            pc_write,
  output logic                            de_en,
  output logic                            de_flush,
  output logic                            ex_bubble,
  output logic [fwd_sel_w(WB_DEPTH)-1:0]  fwd_a_sel,
  output logic [fwd_sel_w(WB_DEPTH)-1:0]  fwd_b_sel,
  output logic [CNT_W-1:0]                stall_cnt
);
  localparam int SW = fwd_sel_w(WB_DEPTH);

  sb_entry_t [WB_DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;

  logic       uses_rs1, uses_rs2, writes_rd, is_load;
  logic [4:0] rs1, rs2, rd;

  hazard_decode u_dec (
    .ir(de_ir), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .writes_rd(writes_rd),
    .is_load(is_load), .rs1(rs1), .rs2(rs2), .rd(rd)
  );

  logic          hit_a, hit_b, ld_a, ld_b, hazard, stall;
  logic [SW-1:0] sel_a, sel_b;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    hit_a = 1'b0; hit_b = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
    sel_a = '0;   sel_b = '0;
    for (int i = WB_DEPTH - 1; i >= 0; i--) begin
      if (uses_rs1 && rs1 != 5'd0 && sb_q[i].valid && sb_q[i].rd == rs1) begin
        hit_a = 1'b1;
        sel_a = SW'(i + 1);
        ld_a  = sb_q[i].is_load && (i < LOAD_LAT);
      end
      if (uses_rs2 && rs2 != 5'd0 && sb_q[i].valid && sb_q[i].rd == rs2) begin
        hit_b = 1'b1;
        sel_b = SW'(i + 1);
        ld_b  = sb_q[i].is_load && (i < LOAD_LAT);
      end
    end
  end

`ifdef HZD_FORWARD_EN
  assign hazard    = ld_a || ld_b;
  assign fwd_a_sel = (rst || stall) ? '0 : sel_a;
  assign fwd_b_sel = (rst || stall) ? '0 : sel_b;
`else
  logic unused_fwd;
  assign unused_fwd = ^{sel_a, sel_b, ld_a, ld_b};
  assign hazard     = hit_a || hit_b;
  assign fwd_a_sel  = '0;
  assign fwd_b_sel  = '0;
`endif

  // A taken branch overrides any stall; reset forces the issue state.
  assign stall     = !rst && de_valid && !br_taken && hazard;
  assign pc_write  = !stall;
  assign de_en     = !stall;
  assign de_flush  = !rst && br_taken;
  assign ex_bubble = !rst && (stall || br_taken);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    sb_d = '0;
    for (int i = 1; i < WB_DEPTH; i++) sb_d[i] = sb_q[i-1];
    if (de_valid && !stall && !br_taken && writes_rd)
      sb_d[0] = '{valid: 1'b1, rd: rd, is_load: is_load};
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
